// File: rtl/dense_feeder.sv
// Operand feeder for the band-matrix systolic array: buffers A/B words per lane
// and replays them as diagonally skewed data/valid streams on start.
module dense_feeder #(
    parameter int N          = 3,
    parameter int LANES      = 5,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int SKEW       = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic                          wr_sel,
    input  logic [$clog2(LANES)-1:0]      wr_lane,
    input  logic [$clog2(DEPTH)-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH+1)-1:0]    len,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [LANES*DATA_WIDTH-1:0]   a_out_bus,
    output logic [LANES-1:0]              valid_bit_a_out,
    output logic [LANES*DATA_WIDTH-1:0]   b_out_bus,
    output logic [LANES-1:0]              valid_bit_b_out
);

    localparam int LW   = $clog2(LANES);
    localparam int AW   = $clog2(DEPTH);
    localparam int LENW = $clog2(DEPTH + 1);
    localparam int CW   = $clog2(DEPTH + (LANES - 1) * SKEW + 1);

    if (LANES != N + 2) begin : g_lanes_check
        $error("dense_feeder: LANES must equal N+2");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t                        state;
    logic [CW-1:0]                 cnt;
    logic [LENW-1:0]               len_q;
    logic                          zero_pend;
    logic [LENW-1:0]               len_clamped;
    logic [CW-1:0]                 last_t;
    logic [LANES*DATA_WIDTH-1:0]   nxt_a;
    logic [LANES*DATA_WIDTH-1:0]   nxt_b;
    logic [LANES-1:0]              nxt_va;

    logic [DATA_WIDTH-1:0] mem_a [LANES][DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [LANES][DEPTH];

    assign len_clamped = (len > LENW'(DEPTH)) ? LENW'(DEPTH) : len;
    assign last_t      = CW'(len_q) + CW'((LANES - 1) * SKEW);

    // Buffer write port; memories deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && {1'b0, wr_lane} < (LW + 1)'(LANES)) begin
            if (wr_sel)
                mem_b[wr_lane][wr_addr] <= wr_data;
            else
                mem_a[wr_lane][wr_addr] <= wr_data;
        end
    end

    // Lane k sees schedule index cnt delayed by k*SKEW; rel is its word index.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [CW-1:0] LO = CW'(k * SKEW);
        logic [CW-1:0] rel;
        logic          hit;
        assign rel       = cnt - LO;
        assign hit       = (cnt >= LO) && (rel < CW'(len_q));
        assign nxt_va[k] = hit;
        assign nxt_a[k*DATA_WIDTH +: DATA_WIDTH] = hit ? mem_a[k][rel[AW-1:0]] : '0;
        assign nxt_b[k*DATA_WIDTH +: DATA_WIDTH] = hit ? mem_b[k][rel[AW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            len_q           <= '0;
            zero_pend       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            a_out_bus       <= '0;
            b_out_bus       <= '0;
            valid_bit_a_out <= '0;
            valid_bit_b_out <= '0;
        end else begin
            done      <= zero_pend;
            zero_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_clamped == '0) begin
                            zero_pend <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            len_q <= len_clamped;
                        end
                    end
                end
                RUN: begin
                    if (cnt == last_t) begin
                        state           <= IDLE;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        a_out_bus       <= '0;
                        b_out_bus       <= '0;
                        valid_bit_a_out <= '0;
                        valid_bit_b_out <= '0;
                    end else begin
                        a_out_bus       <= nxt_a;
                        b_out_bus       <= nxt_b;
                        valid_bit_a_out <= nxt_va;
                        valid_bit_b_out <= nxt_va;
                        cnt             <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_feeder.sv
// Directed bench for dense_feeder: per-cycle snapshots of all outputs compared
// against a hand-derived schedule (SKEW=1, A=16k+i, B=0x80+16k+i).
module tb_dense_feeder;

    localparam int LANES = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(LANES);
    localparam int AW    = $clog2(DEPTH);
    localparam int LENW  = $clog2(DEPTH + 1);
    localparam int SW    = 2 * LANES * DW + 2 * LANES + 2;

    typedef logic [SW-1:0] snap_t;

    logic                  clk;
    logic                  rst_n;
    logic                  wr_en;
    logic                  wr_sel;
    logic [LW-1:0]         wr_lane;
    logic [AW-1:0]         wr_addr;
    logic [DW-1:0]         wr_data;
    logic [LENW-1:0]       len;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [LANES*DW-1:0]   a_out_bus;
    logic [LANES-1:0]      valid_bit_a_out;
    logic [LANES*DW-1:0]   b_out_bus;
    logic [LANES-1:0]      valid_bit_b_out;

    int    checks = 0;
    int    passes = 0;
    snap_t cap [40];

    dense_feeder #(
        .N          (3),
        .LANES      (LANES),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .SKEW       (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_sel          (wr_sel),
        .wr_lane         (wr_lane),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .len             (len),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .a_out_bus       (a_out_bus),
        .valid_bit_a_out (valid_bit_a_out),
        .b_out_bus       (b_out_bus),
        .valid_bit_b_out (valid_bit_b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs in cycle c of a single run launched at E0 with ln words per lane.
    function automatic snap_t exp_snap(input int c, input int ln);
        logic [LANES*DW-1:0] ea, eb;
        logic [LANES-1:0]    ev;
        logic                e_busy, e_done;
        int                  t;
        ea = '0;
        eb = '0;
        ev = '0;
        t  = c - 1;
        for (int k = 0; k < LANES; k++) begin
            if (t >= k && t < k + ln) begin
                ev[k]          = 1'b1;
                ea[k*DW +: DW] = DW'(16 * k + (t - k));
                eb[k*DW +: DW] = DW'(128 + 16 * k + (t - k));
            end
        end
        e_busy = (ln > 0) && (c >= 0) && (c <= ln + LANES - 1);
        e_done = (ln > 0) ? (c == ln + LANES) : (c == 1);
        return {ea, ev, eb, ev, e_busy, e_done};
    endfunction

    function automatic snap_t sample();
        return {a_out_bus, valid_bit_a_out, b_out_bus, valid_bit_b_out, busy, done};
    endfunction

    task automatic write_word(input logic sel, input int lane, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_lane = LW'(lane);
        wr_addr = AW'(addr);
        wr_data = DW'(data);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Launch with start sampled at E0, then record ncyc cycles; optional mid-run events per cycle.
    task automatic run(input int ln, input int ncyc, input int st_from, input int st_to,
                       input int wr_cyc, input int rst_cyc);
        len   = LENW'(ln);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < ncyc; c++) begin
            start   = (c >= st_from && c <= st_to);
            wr_en   = (c == wr_cyc);
            wr_sel  = 1'b0;
            wr_lane = '0;
            wr_addr = '0;
            wr_data = 8'hFF;
            rst_n   = (c != rst_cyc);
            @(negedge clk);
            cap[c] = sample();
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wr_en = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        snap_t s;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_lane = '0; wr_addr = '0; wr_data = '0;
        len = '0; start = 1'b0;
        #2;
        s = sample();
        checks++;
        if (s !== '0) $display("FAIL reset_async got %h exp 0", s); else passes++;
        @(negedge clk);
        s = sample();
        checks++;
        if (s !== '0) $display("FAIL reset_held got %h exp 0", s); else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_all();
        for (int k = 0; k < LANES; k++)
            for (int i = 0; i < DEPTH; i++) begin
                write_word(1'b0, k, i, 16 * k + i);
                write_word(1'b1, k, i, 128 + 16 * k + i);
            end
        write_word(1'b0, 5, 0, 8'hEE);
        write_word(1'b1, 7, 0, 8'hEE);
    endtask

    task automatic test_basic();
        snap_t e;
        run(3, 10, -1, -2, -1, -1);
        for (int c = 0; c < 10; c++) begin
            e = exp_snap(c, 3);
            checks++;
            if (cap[c] !== e) $display("FAIL basic c=%0d got %h exp %h", c, cap[c], e); else passes++;
        end
    endtask

    task automatic test_zero_len();
        snap_t e;
        run(0, 4, -1, -2, -1, -1);
        for (int c = 0; c < 4; c++) begin
            e = exp_snap(c, 0);
            checks++;
            if (cap[c] !== e) $display("FAIL zero_len c=%0d got %h exp %h", c, cap[c], e); else passes++;
        end
    endtask

    task automatic test_interference();
        snap_t e;
        run(3, 11, 4, 4, 2, -1);
        for (int c = 0; c < 11; c++) begin
            e = exp_snap(c, 3);
            checks++;
            if (cap[c] !== e) $display("FAIL interfere c=%0d got %h exp %h", c, cap[c], e); else passes++;
        end
        run(3, 10, -1, -2, -1, -1);
        for (int c = 0; c < 10; c++) begin
            e = exp_snap(c, 3);
            checks++;
            if (cap[c] !== e) $display("FAIL rerun c=%0d got %h exp %h", c, cap[c], e); else passes++;
        end
    endtask

    task automatic test_len_clamp();
        snap_t e;
        run(10, 15, -1, -2, -1, -1);
        for (int c = 0; c < 15; c++) begin
            e = exp_snap(c, 8);
            checks++;
            if (cap[c] !== e) $display("FAIL len_clamp c=%0d got %h exp %h", c, cap[c], e); else passes++;
        end
    endtask

    task automatic test_reset_mid_run();
        snap_t e;
        run(3, 10, -1, -2, -1, 4);
        for (int c = 0; c < 10; c++) begin
            e = (c < 4) ? exp_snap(c, 3) : '0;
            checks++;
            if (cap[c] !== e) $display("FAIL mid_reset c=%0d got %h exp %h", c, cap[c], e); else passes++;
        end
        run(3, 10, -1, -2, -1, -1);
        for (int c = 0; c < 10; c++) begin
            e = exp_snap(c, 3);
            checks++;
            if (cap[c] !== e) $display("FAIL replay c=%0d got %h exp %h", c, cap[c], e); else passes++;
        end
    endtask

    // start held through the done cycle (8): second run's start-sampling edge ends cycle 8.
    task automatic test_back_to_back();
        snap_t e;
        run(3, 20, 0, 8, -1, -1);
        for (int c = 0; c < 20; c++) begin
            e = exp_snap(c, 3) | exp_snap(c - 9, 3);
            checks++;
            if (cap[c] !== e) $display("FAIL back_to_back c=%0d got %h exp %h", c, cap[c], e); else passes++;
        end
    endtask

    initial begin
        test_reset();
        load_all();
        test_basic();
        test_zero_len();
        test_interference();
        test_len_clamp();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
